conv_dnn_bridge: RTL and testbench

Parameterised elastic buffer between the convolution/pooling pipeline and the dense network. Captures per-channel tagged multi-lane feature words plus set-done markers into a FIFO, and narrows each lane from BitSize to OutBitSize with optional shift and saturation. It replaces the fixed single register stage between the two sub-tops. It adds backpressure with skid headroom, marker-only entries, overflow detection and occupancy reporting.

---
 rtl/conv_dnn_pkg.sv | 46 ++++
 rtl/conv_dnn_bridge_fifo.sv | 83 ++++++++
 rtl/conv_dnn_bridge.sv | 109 ++++++++++
 tb/tb_conv_dnn_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_dnn_pkg.sv
// Shared types and helpers for the conv-to-dense bridge: entry layout,
// occupancy counter width and the lane narrowing function.
package conv_dnn_pkg;

    localparam int DEF_BIT_SIZE     = 32;
    localparam int DEF_OUT_BIT_SIZE = 16;
    localparam int DEF_NUM_LANES    = 2;
    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_DEPTH        = 8;
    localparam int DEF_CNT_W        = $clog2(DEF_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_NUM_CHANNELS-1:0]               tag;
        logic [DEF_NUM_LANES*DEF_OUT_BIT_SIZE-1:0] lanes;
        logic                                      set_done;
    } dnn_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Value arrives sign-extended to 64 bits; caller keeps the low out_bits.
    function automatic logic signed [63:0] sat_narrow(
        input logic signed [63:0] value,
        input int                 shift,
        input int                 out_bits,
        input logic               saturate
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] result;
        shifted = value >>> shift;
        max_v   = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_bits - 1));
        if (saturate && (shifted > max_v)) begin
            result = max_v;
        end else if (saturate && (shifted < min_v)) begin
            result = min_v;
        end else begin
            result = shifted;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_dnn_bridge_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head
// entry and occupancy count; accept/drop decisions are made by the caller.
module bridge_fifo #(
    parameter type entry_t = logic [7:0],
    parameter int  Depth   = 8,
    parameter int  CntW    = $clog2(Depth) + 1
) (
    input  logic            clk,
    input  logic            res,
    input  logic            push_i,
    input  logic            pop_i,
    input  entry_t          wdata_i,
    output entry_t          rdata_o,
    output logic [CntW-1:0] count_o,
    output logic [CntW-1:0] count_next_o
);

    localparam int PtrW = $clog2(Depth);

    entry_t            mem_q [Depth];
    entry_t            head_q;
    entry_t            head_d;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   rd_next_s;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_d;

    // Next count and next head entry after this edge's push/pop.
    always_comb begin
        cnt_d     = cnt_q;
        head_d    = head_q;
        rd_next_s = rd_ptr_q + 1'b1;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // A push lands on the head slot when the FIFO is, or becomes, empty.
        if (cnt_d == CntW'(0)) begin
            head_d = '0;
        end else if (push_i && ((cnt_q == CntW'(0)) || (pop_i && (cnt_q == CntW'(1))))) begin
            head_d = wdata_i;
        end else if (pop_i) begin
            head_d = mem_q[rd_next_s];
        end else begin
            head_d = head_q;
        end
    end

    // Pointers, count and registered head.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_next_s;
            end
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o      = head_q;
    assign count_o      = cnt_q;
    assign count_next_o = cnt_d;

endmodule

// File: rtl/conv_dnn_bridge.sv
// Elastic buffer between the conv/pool pipeline and the dense network:
// narrows each lane, queues tagged words and set-done markers with backpressure.
module conv_dnn_bridge
    import conv_dnn_pkg::*;
#(
    parameter int BitSize     = 32,
    parameter int OutBitSize  = 16,
    parameter int NumLanes    = 2,
    parameter int NumChannels = 4,
    parameter int Depth       = 8,
    parameter int Skid        = 2,
    parameter int FracShift   = 0,
    parameter int Saturate    = 1
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic [NumChannels-1:0]         in_valid,
    input  logic [NumLanes*BitSize-1:0]    in_data,
    input  logic                           in_set_done,
    output logic                           out_ready,
    input  logic                           dn_ready,
    output logic [NumChannels-1:0]         out_valid,
    output logic [NumLanes*OutBitSize-1:0] out_data,
    output logic                           out_set_done,
    output logic [cnt_width(Depth)-1:0]    out_count,
    output logic                           out_overflow
);

    localparam int CntW = cnt_width(Depth);

    typedef struct packed {
        logic [NumChannels-1:0]         tag;
        logic [NumLanes*OutBitSize-1:0] lanes;
        logic                           set_done;
    } bridge_entry_t;

    bridge_entry_t             wr_entry_s;
    bridge_entry_t             head_s;
    logic [NumLanes*OutBitSize-1:0] conv_lanes_s;
    logic [CntW-1:0]           count_s;
    logic [CntW-1:0]           count_next_s;
    logic                      push_req_s;
    logic                      pop_s;
    logic                      full_s;
    logic                      push_en_s;
    logic                      out_ready_q;
    logic                      overflow_q;

    // Per-lane shift and narrow ahead of storage.
    always_comb begin
        logic [BitSize-1:0]  lane_v;
        logic signed [63:0]  ext_v;
        logic signed [63:0]  narrow_v;
        conv_lanes_s = '0;
        lane_v       = '0;
        ext_v        = '0;
        narrow_v     = '0;
        for (int l = 0; l < NumLanes; l++) begin
            lane_v   = in_data[l*BitSize +: BitSize];
            ext_v    = {{(64-BitSize){lane_v[BitSize-1]}}, lane_v};
            narrow_v = sat_narrow(ext_v, FracShift, OutBitSize, Saturate != 0);
            conv_lanes_s[l*OutBitSize +: OutBitSize] = narrow_v[OutBitSize-1:0];
        end
    end

    assign push_req_s = (|in_valid) | in_set_done;
    assign pop_s      = (count_s != CntW'(0)) & dn_ready;
    assign full_s     = (count_s == CntW'(Depth));
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_en_s  = push_req_s & (~full_s | pop_s);

    assign wr_entry_s.tag      = in_valid;
    assign wr_entry_s.lanes    = conv_lanes_s;
    assign wr_entry_s.set_done = in_set_done;

    bridge_fifo #(
        .entry_t (bridge_entry_t),
        .Depth   (Depth),
        .CntW    (CntW)
    ) u_fifo (
        .clk          (clk),
        .res          (res),
        .push_i       (push_en_s),
        .pop_i        (pop_s),
        .wdata_i      (wr_entry_s),
        .rdata_o      (head_s),
        .count_o      (count_s),
        .count_next_o (count_next_s)
    );

    // Upstream ready from post-edge occupancy, sticky overflow on dropped push.
    always_ff @(posedge clk) begin
        if (res) begin
            out_ready_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            out_ready_q <= (count_next_s < CntW'(Depth - Skid));
            overflow_q  <= overflow_q | (push_req_s & full_s & ~pop_s);
        end
    end

    assign out_ready    = out_ready_q;
    assign out_overflow = overflow_q;
    assign out_valid    = head_s.tag;
    assign out_data     = head_s.lanes;
    assign out_set_done = head_s.set_done;
    assign out_count    = count_s;

endmodule

// File: tb/tb_conv_dnn_bridge.sv
// Directed bench for conv_dnn_bridge: conversion vectors on three parameter
// sets, then backpressure, overflow, full push+pop, markers and reset flush.
module tb_conv_dnn_bridge;

    logic        clk;
    logic        res;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic        in_set_done;
    logic        dn_ready;

    logic        out_ready, out_set_done, out_overflow;
    logic [3:0]  out_valid, out_count;
    logic [31:0] out_data;

    logic        t_ready, t_sd, t_ovf;
    logic [3:0]  t_valid, t_count;
    logic [31:0] t_data;

    logic        s_ready, s_sd, s_ovf;
    logic [3:0]  s_valid, s_count;
    logic [31:0] s_data;

    int total = 0;
    int bad   = 0;

    conv_dnn_bridge dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .out_ready(out_ready), .dn_ready(dn_ready),
        .out_valid(out_valid), .out_data(out_data), .out_set_done(out_set_done),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    conv_dnn_bridge #(.Saturate(0)) dut_trunc (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .out_ready(t_ready), .dn_ready(dn_ready),
        .out_valid(t_valid), .out_data(t_data), .out_set_done(t_sd),
        .out_count(t_count), .out_overflow(t_ovf)
    );

    conv_dnn_bridge #(.FracShift(4)) dut_shift (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .out_ready(s_ready), .dn_ready(dn_ready),
        .out_valid(s_valid), .out_data(s_data), .out_set_done(s_sd),
        .out_count(s_count), .out_overflow(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] l0;
        logic [31:0] l1;
        logic [31:0] exp_sat;
        logic [31:0] exp_trn;
        logic [31:0] exp_shf;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] tag, input logic [31:0] l0, input logic sd);
        in_valid    = tag;
        in_data     = {32'h0000_0000, l0};
        in_set_done = sd;
        @(posedge clk);
        #1;
        in_valid    = 4'b0000;
        in_data     = 64'h0;
        in_set_done = 1'b0;
    endtask

    task automatic do_reset();
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b0001, 32'h0000_1234, 32'hFFFF_FFFE, 32'hFFFE_1234, 32'hFFFE_1234, 32'hFFFF_0123};
        vecs[1] = '{4'b0010, 32'h0001_0000, 32'h8000_0000, 32'h8000_7FFF, 32'h0000_0000, 32'h8000_1000};
        vecs[2] = '{4'b0100, 32'h0000_0120, 32'h0000_7FFF, 32'h7FFF_0120, 32'h7FFF_0120, 32'h07FF_0012};
        vecs[3] = '{4'b1000, 32'hFFFF_8000, 32'h0000_8000, 32'h7FFF_8000, 32'h8000_8000, 32'h0800_F800};
        vecs[4] = '{4'b0011, 32'h7FFF_FFFF, 32'hFFFF_7FFF, 32'h8000_7FFF, 32'h7FFF_FFFF, 32'hF7FF_7FFF};

        res = 1'b1; in_valid = 4'b0000; in_data = 64'h0; in_set_done = 1'b0; dn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(out_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sd", 64'(out_set_done), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_ovf", 64'(out_overflow), 64'd0);
        res = 1'b0;

        // Conversion vectors: one cycle latency, popped the following edge.
        dn_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = vecs[i].tag;
            in_data  = {vecs[i].l1, vecs[i].l0};
            @(posedge clk);
            #1;
            in_valid = 4'b0000;
            in_data  = 64'h0;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].tag));
            chk($sformatf("vec%0d_sat", i), 64'(out_data), 64'(vecs[i].exp_sat));
            chk($sformatf("vec%0d_trunc", i), 64'(t_data), 64'(vecs[i].exp_trn));
            chk($sformatf("vec%0d_shift", i), 64'(s_data), 64'(vecs[i].exp_shf));
            chk($sformatf("vec%0d_count1", i), 64'(out_count), 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_count0", i), 64'(out_count), 64'd0);
            chk($sformatf("vec%0d_empty", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: ready falls at occupancy 6, two skid words still fit.
        dn_ready = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            push(4'b0001, 32'(j), 1'b0);
            chk($sformatf("bp_count%0d", j), 64'(out_count), 64'(j));
            chk($sformatf("bp_ready%0d", j), 64'(out_ready), (j < 6) ? 64'd1 : 64'd0);
            chk($sformatf("bp_hold%0d", j), 64'(out_data), 64'd1);
        end
        push(4'b0001, 32'd9, 1'b0);
        chk("ovf_count", 64'(out_count), 64'd8);
        chk("ovf_flag", 64'(out_overflow), 64'd1);
        dn_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            chk($sformatf("drain%0d", j), 64'(out_data), 64'(j));
            @(posedge clk);
            #1;
        end
        chk("drain_count", 64'(out_count), 64'd0);
        chk("drain_empty", 64'(out_valid), 64'd0);
        chk("ovf_sticky", 64'(out_overflow), 64'd1);

        // Reset with five queued entries flushes everything.
        dn_ready = 1'b0;
        for (int j = 1; j <= 5; j++) push(4'b0100, 32'h20 + 32'(j), 1'b0);
        chk("pre_rst_count", 64'(out_count), 64'd5);
        do_reset();
        chk("flush_count", 64'(out_count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ovf", 64'(out_overflow), 64'd0);
        chk("flush_ready", 64'(out_ready), 64'd1);
        chk("flush_data", 64'(out_data), 64'd0);
        push(4'b0001, 32'h55, 1'b0);
        chk("post_rst_count", 64'(out_count), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h55);
        dn_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_pop", 64'(out_count), 64'd0);

        // Full FIFO with simultaneous push and pop.
        dn_ready = 1'b0;
        for (int j = 1; j <= 8; j++) push(4'b0001, 32'h40 + 32'(j), 1'b0);
        chk("full_count", 64'(out_count), 64'd8);
        dn_ready = 1'b1;
        push(4'b0001, 32'h49, 1'b0);
        chk("pp_count", 64'(out_count), 64'd8);
        chk("pp_ovf", 64'(out_overflow), 64'd0);
        for (int j = 2; j <= 9; j++) begin
            chk($sformatf("pp_drain%0d", j), 64'(out_data), 64'h40 + 64'(j));
            @(posedge clk);
            #1;
        end
        chk("pp_empty", 64'(out_count), 64'd0);

        // Marker-only entry and marker carried with data.
        dn_ready = 1'b0;
        push(4'b0001, 32'h10, 1'b0);
        push(4'b0001, 32'h11, 1'b0);
        push(4'b0001, 32'h12, 1'b0);
        push(4'b0000, 32'h0, 1'b1);
        push(4'b0010, 32'h13, 1'b1);
        chk("sd_count", 64'(out_count), 64'd5);
        dn_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("sd_word%0d_valid", j), 64'(out_valid), 64'd1);
            chk($sformatf("sd_word%0d_sd", j), 64'(out_set_done), 64'd0);
            chk($sformatf("sd_word%0d_data", j), 64'(out_data), 64'h10 + 64'(j));
            @(posedge clk);
            #1;
        end
        chk("sd_marker_valid", 64'(out_valid), 64'd0);
        chk("sd_marker_sd", 64'(out_set_done), 64'd1);
        @(posedge clk);
        #1;
        chk("sd_both_valid", 64'(out_valid), 64'd2);
        chk("sd_both_sd", 64'(out_set_done), 64'd1);
        chk("sd_both_data", 64'(out_data), 64'h13);
        @(posedge clk);
        #1;
        chk("sd_final_count", 64'(out_count), 64'd0);
        chk("sd_final_sd", 64'(out_set_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
